// File: rtl/pipe_stage_reg.sv
// Single-stage pipeline register with flush-to-default and hold (stall).
// Define PIPE_REG_PARITY_EN to add a stored-parity flop and live parity checking.
module pipe_stage_reg #(
  parameter int              dw      = 32,
  parameter logic [dw-1:0]   RST_VAL = {dw{1'b0}}
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          set_default,
  input  logic          hold_en,
  input  logic [dw-1:0] default_data_i,
  input  logic [dw-1:0] data_i,
  output logic [dw-1:0] data_o,
  output logic          parity_err_o
);

  logic [dw-1:0] data_q, data_d;
  logic          load;

  // Flush outranks hold; reset outranks both in the register below.
  always_comb begin
    load   = set_default | ~hold_en;
    data_d = data_q;
    if (set_default)   data_d = default_data_i;
    else if (!hold_en) data_d = data_i;
  end

  // rst_n is active-high despite its name.
  always_ff @(posedge clk) begin
    if (rst_n) data_q <= RST_VAL;
    else       data_q <= data_d;
  end

  assign data_o = data_q;

`ifdef PIPE_REG_PARITY_EN
  logic par_q, par_d;

  // Parity is captured only on loads so a corrupted word stays flagged through a hold.
  always_comb begin
    par_d = par_q;
    if (load) par_d = ^data_d;
  end

  always_ff @(posedge clk) begin
    if (rst_n) par_q <= ^RST_VAL;
    else       par_q <= par_d;
  end

  assign parity_err_o = (^data_q) ^ par_q;
`else
  logic unused_load;
  assign unused_load  = load;
  assign parity_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg: a 32-bit and an 8-bit (RST_VAL=0x5A) instance
// share controls; a monitor checks every cycle against a priority-rule reference model.
module tb_pipe_stage_reg;

  logic        clk = 1'b0;
  logic        rst_n, set_default, hold_en;
  logic [31:0] default_data_i, data_i;
  logic [31:0] data_o;
  logic [7:0]  data8_o;
  logic        perr_o, perr8_o;

  always #5 clk = ~clk;

  pipe_stage_reg #(.dw(32)) u_dut (
    .clk(clk), .rst_n(rst_n), .set_default(set_default), .hold_en(hold_en),
    .default_data_i(default_data_i), .data_i(data_i),
    .data_o(data_o), .parity_err_o(perr_o)
  );

  pipe_stage_reg #(.dw(8), .RST_VAL(8'h5A)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .set_default(set_default), .hold_en(hold_en),
    .default_data_i(default_data_i[7:0]), .data_i(data_i[7:0]),
    .data_o(data8_o), .parity_err_o(perr8_o)
  );

  typedef struct {
    logic [31:0] d32;
    logic [7:0]  d8;
    logic        perr;
    string       name;
  } exp_t;

  exp_t        exp_q[$];
  int          vectors = 0;
  int          miscompares = 0;

  // Reference model: the stored word of each instance plus a "corrupted" flag.
  logic [31:0] m32;
  logic [7:0]  m8;
  logic        m_perr = 1'b0;

  task automatic step(input logic r, input logic sd, input logic he,
                      input logic [31:0] dd, input logic [31:0] di, input string nm);
    exp_t e;
    @(negedge clk);
    rst_n = r; set_default = sd; hold_en = he; default_data_i = dd; data_i = di;
    if (r)       begin m32 = 32'h0; m8 = 8'h5A; m_perr = 1'b0; end
    else if (sd) begin m32 = dd;    m8 = dd[7:0]; m_perr = 1'b0; end
    else if (!he) begin m32 = di;   m8 = di[7:0]; m_perr = 1'b0; end
    e.d32 = m32; e.d8 = m8; e.perr = m_perr; e.name = nm;
    exp_q.push_back(e);
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      vectors++;
      if (data_o !== e.d32) begin
        miscompares++;
        $display("FAIL %s data32: got %h expected %h", e.name, data_o, e.d32);
      end
      if (data8_o !== e.d8) begin
        miscompares++;
        $display("FAIL %s data8: got %h expected %h", e.name, data8_o, e.d8);
      end
      if (perr_o !== e.perr) begin
        miscompares++;
        $display("FAIL %s parity_err: got %b expected %b", e.name, perr_o, e.perr);
      end
      if (perr8_o !== 1'b0) begin
        miscompares++;
        $display("FAIL %s parity_err8: got %b expected 0", e.name, perr8_o);
      end
    end
  end

  initial begin
    rst_n = 1'b1; set_default = 1'b0; hold_en = 1'b0;
    default_data_i = 32'h0; data_i = 32'hDEADBEEF;

    step(1, 0, 0, 32'h0, 32'hDEADBEEF, "reset0");
    step(1, 0, 0, 32'h0, 32'hDEADBEEF, "reset1");
    step(0, 0, 0, 32'h0, 32'h11, "pass11");
    step(0, 0, 0, 32'h0, 32'h22, "pass22");
    step(0, 0, 0, 32'h0, 32'h33, "pass33");
    step(0, 0, 0, 32'h0, 32'h22, "pass22b");
    step(0, 0, 1, 32'h0, 32'h44, "hold44");
    step(0, 0, 1, 32'h0, 32'h55, "hold55");
    step(0, 0, 1, 32'h0, 32'h66, "hold66");
    step(0, 0, 0, 32'h0, 32'h77, "release77");
    step(0, 1, 0, 32'h13, 32'h99, "flush");
    step(0, 0, 0, 32'h0, 32'h88, "pass88");
    step(0, 1, 1, 32'h13, 32'h99, "flush_over_hold");
    step(0, 0, 0, 32'hFFFF_FFFF, 32'hA5A5_5A5A, "dd_ignored");
    step(1, 1, 1, 32'hAB, 32'hCC, "reset_priority");
    step(0, 0, 1, 32'hAB, 32'hCC, "hold_after_reset");
    step(0, 0, 0, 32'hAB, 32'hCAFEF00D, "first_after_reset");

    for (int i = 0; i < 300; i++) begin
      step(($urandom_range(0, 39) == 0), ($urandom_range(0, 7) == 0),
           ($urandom_range(0, 2) == 0), $urandom, $urandom, "random");
    end

`ifdef PIPE_REG_PARITY_EN
    // Corrupt the stored word while holding; the flag must persist until a load.
    step(0, 0, 0, 32'h0, 32'h1234_5678, "par_load");
    @(negedge clk);
    rst_n = 1'b0; set_default = 1'b0; hold_en = 1'b1;
    force u_dut.data_q = m32 ^ 32'h0000_0100;
    #1 release u_dut.data_q;
    m32 = m32 ^ 32'h0000_0100;
    m_perr = 1'b1;
    step(0, 0, 1, 32'h0, 32'hFFFF_0000, "par_flip_hold0");
    step(0, 0, 1, 32'h0, 32'hFFFF_0001, "par_flip_hold1");
    step(0, 0, 0, 32'h0, 32'h0BAD_CAFE, "par_reload");
    step(0, 0, 0, 32'h0, 32'h0000_0001, "par_after");
`endif

    // Drain the scoreboard within a bounded number of cycles.
    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(posedge clk);
    @(negedge clk);
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
